// File: rtl/stage_writeback.sv
// Register-file write port: selects destination, data and enable for each retiring
// instruction, merging pipeline writes with mult/div results via a 1-entry hold buffer.
module stage_writeback #(
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned LINK_REG    = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_ALU_op,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_data,
  input  logic [31:0] in_pc_plus1,
  input  logic [26:0] in_target,
  input  logic        in_ovf,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_is_div,
  output logic        md_ready,
  output logic        stall_wb,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        pending_valid,
  output logic [4:0]  pending_rd
);

  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpJal   = 5'b00011;
  localparam logic [4:0] OpSetx  = 5'b10101;
  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluSub  = 5'b00001;
  localparam logic [4:0] AluMul  = 5'b00110;
  localparam logic [4:0] AluDiv  = 5'b00111;
  localparam logic [4:0] RegStat = 5'(RSTATUS_REG);
  localparam logic [4:0] RegLink = 5'(LINK_REG);

  typedef enum logic {StEmpty, StHeld} state_e;

  state_e      r_state;
  logic        r_we;
  logic [4:0]  r_wreg;
  logic [31:0] r_wdata;
  logic        r_md_ready;
  logic        r_pending_valid;
  logic [4:0]  r_hold_rd;
  logic [31:0] r_hold_data;

  logic        w_pipe_cand;
  logic        w_pipe_wr;
  logic [4:0]  w_pipe_rd;
  logic [31:0] w_pipe_data;
  logic        w_md_wr;
  logic [4:0]  w_md_rd;
  logic [31:0] w_md_data;

  always_comb begin
    w_pipe_cand = 1'b0;
    w_pipe_rd   = in_rd;
    w_pipe_data = in_alu_result;
    if (in_valid) begin
      case (in_opcode)
        OpRtype: begin
          if (in_ALU_op != AluMul && in_ALU_op != AluDiv) begin
            w_pipe_cand = 1'b1;
            if (in_ovf && in_ALU_op == AluAdd) begin
              w_pipe_rd   = RegStat;
              w_pipe_data = 32'd1;
            end else if (in_ovf && in_ALU_op == AluSub) begin
              w_pipe_rd   = RegStat;
              w_pipe_data = 32'd3;
            end
          end
        end
        OpAddi: begin
          w_pipe_cand = 1'b1;
          if (in_ovf) begin
            w_pipe_rd   = RegStat;
            w_pipe_data = 32'd2;
          end
        end
        OpLw: begin
          w_pipe_cand = 1'b1;
          w_pipe_data = in_mem_data;
        end
        OpJal: begin
          w_pipe_cand = 1'b1;
          w_pipe_rd   = RegLink;
          w_pipe_data = in_pc_plus1;
        end
        OpSetx: begin
          w_pipe_cand = 1'b1;
          w_pipe_rd   = RegStat;
          w_pipe_data = {5'b0, in_target};
        end
        default: ;
      endcase
    end
  end

  // Writes to r0 are dropped entirely so they never claim the port or the buffer.
  assign w_pipe_wr = w_pipe_cand && (w_pipe_rd != 5'd0);
  assign w_md_rd   = md_exception ? RegStat : md_rd;
  assign w_md_data = md_exception ? (md_is_div ? 32'd5 : 32'd4) : md_result;
  assign w_md_wr   = md_valid && (w_md_rd != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= StEmpty;
      r_we            <= 1'b0;
      r_wreg          <= 5'd0;
      r_wdata         <= 32'd0;
      r_md_ready      <= 1'b1;
      r_pending_valid <= 1'b0;
      r_hold_rd       <= 5'd0;
      r_hold_data     <= 32'd0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_pipe_wr) begin
            r_we    <= 1'b1;
            r_wreg  <= w_pipe_rd;
            r_wdata <= w_pipe_data;
            // Same destination: the younger pipeline write supersedes the md result.
            if (w_md_wr && (w_md_rd != w_pipe_rd)) begin
              r_state         <= StHeld;
              r_hold_rd       <= w_md_rd;
              r_hold_data     <= w_md_data;
              r_pending_valid <= 1'b1;
              r_md_ready      <= 1'b0;
            end
          end else if (w_md_wr) begin
            r_we    <= 1'b1;
            r_wreg  <= w_md_rd;
            r_wdata <= w_md_data;
          end else begin
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
          end
        end
        StHeld: begin
          r_we            <= 1'b1;
          r_wreg          <= r_hold_rd;
          r_wdata         <= r_hold_data;
          r_state         <= StEmpty;
          r_pending_valid <= 1'b0;
          r_hold_rd       <= 5'd0;
          r_md_ready      <= 1'b1;
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  assign stall_wb         = (r_state == StHeld) && w_pipe_wr;
  assign md_ready         = r_md_ready;
  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_wdata;
  assign pending_valid    = r_pending_valid;
  assign pending_rd       = r_hold_rd;

endmodule

// File: tb/tb_stage_writeback.sv
// Directed self-checking bench for stage_writeback.
module tb_stage_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_opcode, in_ALU_op, in_rd;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus1;
  logic [26:0] in_target;
  logic        in_ovf;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_exception, md_is_div;
  logic        md_ready, stall_wb, ctrl_writeEnable, pending_valid;
  logic [4:0]  ctrl_writeReg, pending_rd;
  logic [31:0] data_writeReg;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stage_writeback dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_ALU_op(in_ALU_op), .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus1(in_pc_plus1), .in_target(in_target),
    .in_ovf(in_ovf), .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result),
    .md_exception(md_exception), .md_is_div(md_is_div), .md_ready(md_ready),
    .stall_wb(stall_wb), .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending_valid(pending_valid), .pending_rd(pending_rd)
  );

  task automatic clear_inputs();
    in_valid = 0; in_opcode = 0; in_ALU_op = 0; in_rd = 0; in_alu_result = 0;
    in_mem_data = 0; in_pc_plus1 = 0; in_target = 0; in_ovf = 0;
    md_valid = 0; md_rd = 0; md_result = 0; md_exception = 0; md_is_div = 0;
  endtask

  task automatic pipe(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] rd,
                      input logic [31:0] alu, input logic ovf);
    in_valid = 1; in_opcode = op; in_ALU_op = aop; in_rd = rd; in_alu_result = alu; in_ovf = ovf;
  endtask

  task automatic md(input logic [4:0] rd, input logic [31:0] res, input logic exc,
                    input logic dv);
    md_valid = 1; md_rd = rd; md_result = res; md_exception = exc; md_is_div = dv;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    tick(); tick();
    checks++;
    if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
      errors++;
      $display("FAIL reset_write: we=%b reg=%0d data=%h, need 0/0/0",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    checks++;
    if (md_ready !== 1'b1 || pending_valid !== 1'b0 || stall_wb !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: md_ready=%b pending=%b stall=%b, need 1/0/0",
               md_ready, pending_valid, stall_wb);
    end
    reset = 0;
  endtask

  task automatic test_alu();
    logic [4:0]  exp_reg [5] = '{5'd5, 5'd30, 5'd30, 5'd30, 5'd0};
    logic [31:0] exp_dat [5] = '{32'h1234, 32'd1, 32'd3, 32'd2, 32'd0};
    logic        exp_we  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: pipe(5'b00000, 5'b00000, 5'd5, 32'h1234, 0);
        1: pipe(5'b00000, 5'b00000, 5'd5, 32'h1234, 1);
        2: pipe(5'b00000, 5'b00001, 5'd6, 32'h5555, 1);
        3: pipe(5'b00101, 5'b00000, 5'd7, 32'h7777, 1);
        default: pipe(5'b00000, 5'b00110, 5'd5, 32'h9999, 0);
      endcase
      tick();
      checks++;
      if (ctrl_writeEnable !== exp_we[i] ||
          (exp_we[i] && (ctrl_writeReg !== exp_reg[i] || data_writeReg !== exp_dat[i]))) begin
        errors++;
        $display("FAIL alu_%0d: we=%b reg=%0d data=%h, need %b/%0d/%h", i,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, exp_we[i], exp_reg[i], exp_dat[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_jal_setx_lw();
    clear_inputs(); pipe(5'b00011, 5'd0, 5'd9, 32'h0, 0); in_pc_plus1 = 32'h40;
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd31 || data_writeReg !== 32'h40) begin
      errors++;
      $display("FAIL jal: we=%b reg=%0d data=%h, need 1/31/40",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs(); pipe(5'b10101, 5'd0, 5'd9, 32'h0, 0); in_target = 27'h7FFFFFF;
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd30 || data_writeReg !== 32'h07FFFFFF) begin
      errors++;
      $display("FAIL setx: we=%b reg=%0d data=%h, need 1/30/07ffffff",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs(); pipe(5'b01000, 5'd0, 5'd4, 32'h0, 0); in_mem_data = 32'hCAFE;
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd4 || data_writeReg !== 32'hCAFE) begin
      errors++;
      $display("FAIL lw: we=%b reg=%0d data=%h, need 1/4/cafe",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs(); pipe(5'b01000, 5'd0, 5'd0, 32'h0, 0); in_mem_data = 32'hDEAD;
    tick();
    checks++;
    if (ctrl_writeEnable !== 0) begin
      errors++;
      $display("FAIL lw_r0: we=%b, need 0", ctrl_writeEnable);
    end
    clear_inputs();
  endtask

  task automatic test_collision();
    clear_inputs(); pipe(5'b00101, 5'd0, 5'd3, 32'h33, 0); md(5'd7, 32'hBEEF, 0, 0);
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h33) begin
      errors++;
      $display("FAIL coll_pipe: we=%b reg=%0d data=%h, need 1/3/33",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    checks++;
    if (pending_valid !== 1 || pending_rd !== 5'd7 || md_ready !== 0) begin
      errors++;
      $display("FAIL coll_held: pending=%b rd=%0d md_ready=%b, need 1/7/0",
               pending_valid, pending_rd, md_ready);
    end
    clear_inputs();
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd7 || data_writeReg !== 32'hBEEF ||
        pending_valid !== 0 || md_ready !== 1) begin
      errors++;
      $display("FAIL coll_drain: we=%b reg=%0d data=%h pend=%b rdy=%b, need 1/7/beef/0/1",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending_valid, md_ready);
    end
  endtask

  task automatic test_stall();
    clear_inputs(); pipe(5'b00000, 5'd0, 5'd2, 32'h22, 0); md(5'd6, 32'h66, 0, 0);
    tick();
    clear_inputs(); pipe(5'b01000, 5'd0, 5'd4, 32'h0, 0); in_mem_data = 32'h44;
    #1;
    checks++;
    if (stall_wb !== 1) begin
      errors++;
      $display("FAIL stall_held: stall=%b, need 1", stall_wb);
    end
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd6 || data_writeReg !== 32'h66 ||
        stall_wb !== 0) begin
      errors++;
      $display("FAIL stall_drain: we=%b reg=%0d data=%h stall=%b, need 1/6/66/0",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, stall_wb);
    end
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h44) begin
      errors++;
      $display("FAIL stall_replay: we=%b reg=%0d data=%h, need 1/4/44",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs();
  endtask

  task automatic test_md_exception();
    clear_inputs(); md(5'd12, 32'h123, 1, 1);
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd5) begin
      errors++;
      $display("FAIL md_div_exc: we=%b reg=%0d data=%h, need 1/30/5",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs(); md(5'd12, 32'h123, 1, 0);
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd4) begin
      errors++;
      $display("FAIL md_mul_exc: we=%b reg=%0d data=%h, need 1/30/4",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs(); md(5'd11, 32'hABCD, 0, 0);
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd11 || data_writeReg !== 32'hABCD) begin
      errors++;
      $display("FAIL md_direct: we=%b reg=%0d data=%h, need 1/11/abcd",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    clear_inputs();
  endtask

  task automatic test_same_rd();
    clear_inputs(); pipe(5'b00000, 5'd0, 5'd9, 32'h99, 0); md(5'd9, 32'h999, 0, 0);
    tick();
    checks++;
    if (ctrl_writeEnable !== 1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h99 ||
        pending_valid !== 0 || md_ready !== 1) begin
      errors++;
      $display("FAIL same_rd: we=%b reg=%0d data=%h pend=%b rdy=%b, need 1/9/99/0/1",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending_valid, md_ready);
    end
    clear_inputs();
    tick();
    checks++;
    if (ctrl_writeEnable !== 0) begin
      errors++;
      $display("FAIL same_rd_after: we=%b, need 0", ctrl_writeEnable);
    end
  endtask

  task automatic test_reset_held();
    clear_inputs(); pipe(5'b00101, 5'd0, 5'd8, 32'h88, 0); md(5'd13, 32'h1313, 0, 0);
    tick();
    clear_inputs(); reset = 1;
    tick();
    checks++;
    if (pending_valid !== 0 || md_ready !== 1 || ctrl_writeEnable !== 0) begin
      errors++;
      $display("FAIL reset_held: pend=%b rdy=%b we=%b, need 0/1/0",
               pending_valid, md_ready, ctrl_writeEnable);
    end
    reset = 0;
    tick();
    checks++;
    if (ctrl_writeEnable !== 0) begin
      errors++;
      $display("FAIL reset_held_nowrite: we=%b reg=%0d, need 0",
               ctrl_writeEnable, ctrl_writeReg);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #2;
    test_reset();
    test_alu();
    test_jal_setx_lw();
    test_collision();
    test_stall();
    test_md_exception();
    test_same_rd();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
